// File: rtl/locker_arbiter.sv
// Round-robin arbiter that locks one shared 4-phase req/ack channel to a single
// upstream owner for a full return-to-zero cycle. Handshake inputs are synchronized.
module locker_arbiter #(
   parameter int size        = 2,
   parameter int sync_stages = 2,
   parameter int cnt_width   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lock,
   input  logic [size-1:0]      req_in,
   output logic [size-1:0]      ack_in,
   output logic                 req_out,
   input  logic                 ack_out,
   output logic [size-1:0]      grant,
   output logic                 busy,
   output logic [cnt_width-1:0] count
);
   localparam int pw = (size > 1) ? $clog2(size) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      REL  = 2'd3
   } state_t;

   state_t                           state_r;
   logic [sync_stages-1:0][size-1:0] req_pipe_r;
   logic [sync_stages-1:0]           ack_pipe_r;
   logic [size-1:0]                  rs_s;
   logic                             as_s;
   logic [pw-1:0]                    ptr_r;
   logic [pw-1:0]                    gidx_r;
   logic [pw-1:0]                    win_s;
   logic                             any_s;
   logic [pw:0]                      idx_s;

   function automatic logic [size-1:0] onehot(input logic [pw-1:0] i);
      logic [size-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign rs_s = req_pipe_r[sync_stages-1];
   assign as_s = ack_pipe_r[sync_stages-1];

   // Input synchronizer chains for the asynchronous handshake lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_pipe_r <= '0;
         ack_pipe_r <= '0;
      end else begin
         req_pipe_r[0] <= req_in;
         ack_pipe_r[0] <= ack_out;
         for (int k = 1; k < sync_stages; k++) begin
            req_pipe_r[k] <= req_pipe_r[k-1];
            ack_pipe_r[k] <= ack_pipe_r[k-1];
         end
      end
   end

   // Cyclic search from ptr; scanning offsets downward lets the nearest requester win
   always_comb begin
      win_s = ptr_r;
      any_s = 1'b0;
      idx_s = '0;
      for (int i = size - 1; i >= 0; i--) begin
         idx_s = {1'b0, ptr_r} + (pw+1)'(i);
         if (idx_s >= (pw+1)'(size)) begin
            idx_s = idx_s - (pw+1)'(size);
         end else begin
            idx_s = idx_s;
         end
         if (rs_s[idx_s[pw-1:0]]) begin
            win_s = idx_s[pw-1:0];
            any_s = 1'b1;
         end else begin
            any_s = any_s;
         end
      end
   end

   // Handshake sequencer with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         gidx_r  <= '0;
         grant   <= '0;
         ack_in  <= '0;
         req_out <= 1'b0;
         busy    <= 1'b0;
         count   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!lock && any_s && !as_s) begin
                  state_r <= REQ;
                  gidx_r  <= win_s;
                  grant   <= onehot(win_s);
                  req_out <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            REQ: begin
               if (as_s) begin
                  state_r <= HOLD;
                  ack_in  <= grant;
               end
            end
            HOLD: begin
               if (!rs_s[gidx_r]) begin
                  state_r <= REL;
                  req_out <= 1'b0;
               end
            end
            REL: begin
               if (!as_s) begin
                  state_r <= IDLE;
                  ack_in  <= '0;
                  grant   <= '0;
                  busy    <= 1'b0;
                  ptr_r   <= (gidx_r == pw'(size - 1)) ? '0 : gidx_r + pw'(1);
                  count   <= count + cnt_width'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               ack_in  <= '0;
               grant   <= '0;
               req_out <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_locker_arbiter.sv
// Directed and random bench for locker_arbiter against a transaction-level
// reference model with explicit synchronizer delay lines.
module tb_locker_arbiter;
   localparam int SIZE = 2;
   localparam int SYNC = 2;
   localparam int CW   = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            lock;
   logic [SIZE-1:0] req_in;
   logic [SIZE-1:0] ack_in;
   logic            req_out;
   logic            ack_out;
   logic [SIZE-1:0] grant;
   logic            busy;
   logic [CW-1:0]   count;

   int vectors     = 0;
   int miscompares = 0;

   // Model: handshake progress 0=free,1=requested,2=acked,3=releasing
   int              m_phase;
   int              m_owner;
   int              m_ptr;
   int              m_count;
   logic [SIZE-1:0] req_hist[$];
   logic            ack_hist[$];

   always #5 clk = ~clk;

   locker_arbiter #(.size(SIZE), .sync_stages(SYNC), .cnt_width(CW)) dut (
      .clk(clk), .rst(rst), .lock(lock), .req_in(req_in), .ack_in(ack_in),
      .req_out(req_out), .ack_out(ack_out), .grant(grant), .busy(busy), .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_count = 0;
      req_hist.delete();
      ack_hist.delete();
   endtask

   task automatic model_step();
      logic [SIZE-1:0] rs;
      logic            as_v;
      bit              found;
      rs   = (req_hist.size() >= SYNC) ? req_hist[0] : '0;
      as_v = (ack_hist.size() >= SYNC) ? ack_hist[0] : 1'b0;
      req_hist.push_back(req_in);
      ack_hist.push_back(ack_out);
      if (req_hist.size() > SYNC) begin
         void'(req_hist.pop_front());
         void'(ack_hist.pop_front());
      end
      case (m_phase)
         0: if (!lock && rs != '0 && !as_v) begin
               found = 1'b0;
               for (int k = 0; k < SIZE; k++) begin
                  if (!found && rs[(m_ptr + k) % SIZE]) begin
                     m_owner = (m_ptr + k) % SIZE;
                     found   = 1'b1;
                  end
               end
               m_phase = 1;
            end
         1: if (as_v) m_phase = 2;
         2: if (!rs[m_owner]) m_phase = 3;
         3: if (!as_v) begin
               m_phase = 0;
               m_ptr   = (m_owner + 1) % SIZE;
               m_count = (m_count + 1) % (1 << CW);
            end
         default: m_phase = 0;
      endcase
   endtask

   task automatic compare_all();
      logic [SIZE-1:0] g;
      logic [SIZE-1:0] a;
      g = '0;
      if (m_phase != 0) g[m_owner] = 1'b1;
      a = (m_phase >= 2) ? g : '0;
      check("grant",   32'(grant),   32'(g));
      check("ack_in",  32'(ack_in),  32'(a));
      check("req_out", 32'(req_out), 32'(m_phase == 1 || m_phase == 2));
      check("busy",    32'(busy),    32'(m_phase != 0));
      check("count",   32'(count),   32'(m_count));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ack_in"},  32'(ack_in),  32'd0);
      check({tag, "_req_out"}, 32'(req_out), 32'd0);
      check({tag, "_grant"},   32'(grant),   32'd0);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_count"},   32'(count),   32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1 reset_checks("rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int n;
      rst = 1'b1; lock = 1'b0; req_in = '0; ack_out = 1'b0;
      model_reset();
      #12 reset_checks("por");
      @(negedge clk);
      rst = 1'b0;

      // single requester
      req_in = 2'b01;
      step(2); check("a_wait_req_out", 32'(req_out), 32'd0);
      step(1); check("a_req_out", 32'(req_out), 32'd1); check("a_grant", 32'(grant), 32'd1);
      ack_out = 1'b1; step(3); check("a_ack_in", 32'(ack_in), 32'd1);
      req_in = 2'b00; step(3); check("a_req_drop", 32'(req_out), 32'd0);
      ack_out = 1'b0; step(3);
      check("a_ack_clr", 32'(ack_in), 32'd0); check("a_grant_clr", 32'(grant), 32'd0);
      check("a_count", 32'(count), 32'd1);

      // reset mid-HOLD, then simultaneous requests from reset
      req_in = 2'b01; step(3); check("f_grant_wrap", 32'(grant), 32'd1);
      ack_out = 1'b1; step(3);
      #2 rst = 1'b1;
      #1 reset_checks("midhold");
      @(negedge clk);
      rst = 1'b0; model_reset();
      ack_out = 1'b0; req_in = 2'b11;
      step(3); check("b_first", 32'(grant), 32'd1);
      ack_out = 1'b1; step(3);
      req_in = 2'b10; step(3);
      ack_out = 1'b0; step(4); check("b_second", 32'(grant), 32'd2); check("b_count1", 32'(count), 32'd1);
      ack_out = 1'b1; step(3);
      req_in = 2'b00; step(3);
      ack_out = 1'b0; step(3); check("b_count2", 32'(count), 32'd2); check("b_idle", 32'(grant), 32'd0);
      req_in = 2'b11; step(3); check("b_ptr0", 32'(grant), 32'd1);

      // fairness with immediate re-requests
      do_reset();
      req_in = 2'b11;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (grant == '0 && n < 10) begin step(1); n++; end
         check("fair_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
         ack_out = 1'b1; step(3);
         req_in[k % 2] = 1'b0; step(3);
         ack_out = 1'b0; step(3);
         req_in[k % 2] = 1'b1;
      end

      // lock holds off new grants but not an active transaction
      do_reset();
      lock = 1'b1; req_in = 2'b10;
      step(10); check("lock_req_out", 32'(req_out), 32'd0); check("lock_grant0", 32'(grant), 32'd0);
      lock = 1'b0; step(1); check("lock_grant", 32'(grant), 32'd2);
      ack_out = 1'b1; step(3); check("lock_ack_in", 32'(ack_in), 32'd2);
      lock = 1'b1; req_in = 2'b00; step(3);
      ack_out = 1'b0; step(3);
      check("lock_count", 32'(count), 32'd1); check("lock_busy", 32'(busy), 32'd0);
      lock = 1'b0;

      // stale ack held through reset release
      @(negedge clk);
      ack_out = 1'b1; rst = 1'b1;
      #1 reset_checks("stale_rst");
      @(negedge clk);
      rst = 1'b0; model_reset();
      req_in = 2'b01;
      step(8); check("stale_block", 32'(grant), 32'd0);
      ack_out = 1'b0;
      step(2); check("stale_early", 32'(grant), 32'd0);
      step(1); check("stale_grant", 32'(grant), 32'd1);

      // randomized environment
      do_reset();
      req_in = '0; ack_out = 1'b0; lock = 1'b0;
      repeat (1500) begin
         step(1);
         if ($urandom_range(0, 1) == 1) ack_out = req_out;
         for (int i = 0; i < SIZE; i++) begin
            if (req_in[i] && ack_in[i] && $urandom_range(0, 1) == 1) req_in[i] = 1'b0;
            else if (!req_in[i] && !ack_in[i] && $urandom_range(0, 2) == 0) req_in[i] = 1'b1;
         end
         lock = ($urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
